// File: rtl/compuerta_pkg.sv
// Purpose: shared types and defaults for the parking-gate controller.
// Latency: n/a (types, constants and a pure output-decode function).
// Backpressure: n/a.
package compuerta_pkg;

  // Controller states, 3-bit binary encoding.
  typedef enum logic [2:0] {
    CERRADO    = 3'd0,
    ESPERA_PIN = 3'd1,
    ALARMA_PIN = 3'd2,
    ABIERTO    = 3'd3,
    BLOQUEO    = 3'd4
  } estado_t;

  // Gate indications, one bit per output pin.
  typedef struct packed {
    logic cerrado;
    logic abierto;
    logic alarma;
    logic bloqueo;
  } salidas_t;

  localparam logic [7:0] PIN_DEFECTO      = 8'h10;
  localparam int         MAX_INTENTOS_DEF = 3;

  // Moore decode: the gate is physically closed in every state but ABIERTO,
  // so Cerrado/Abierto are always complementary.
  function automatic salidas_t decodificar(input estado_t e);
    salidas_t s;
    s.cerrado = (e != ABIERTO);
    s.abierto = (e == ABIERTO);
    s.alarma  = (e == ALARMA_PIN) || (e == BLOQUEO);
    s.bloqueo = (e == BLOQUEO);
    return s;
  endfunction

endpackage

// File: rtl/control_compuerta_if.sv
// Purpose: gate bus between the stimulus side (master) and the controller (slave).
// Signals: Vehiculo, Termino, enterPin, Pin[7:0] toward the controller;
//          Cerrado, Abierto, Alarma, Bloqueo back from it. No handshake, level signals.
interface control_compuerta_if;

  logic       Vehiculo;
  logic       Termino;
  logic       enterPin;
  logic [7:0] Pin;
  logic       Cerrado;
  logic       Abierto;
  logic       Alarma;
  logic       Bloqueo;

  modport master (
    output Vehiculo, Termino, enterPin, Pin,
    input  Cerrado, Abierto, Alarma, Bloqueo
  );

  modport slave (
    input  Vehiculo, Termino, enterPin, Pin,
    output Cerrado, Abierto, Alarma, Bloqueo
  );

endinterface

// File: rtl/detector_flanco.sv
// Purpose: 1-bit rising-edge detector; pulso = in & ~in_q.
// Latency: combinational pulse in the cycle the input rises; in_q registered.
// Ports: Clk, Reset (async active-low), in, pulso. No backpressure.
module detector_flanco (
  input  logic Clk,
  input  logic Reset,
  input  logic in,
  output logic pulso
);

  logic in_q;

  // in_q resets to 0 so an input already high on the first edge after
  // reset release still counts as a rising edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in;
    end
  end

  assign pulso = in & ~in_q;

endmodule

// File: rtl/control_compuerta.sv
// Purpose: parking-gate Moore FSM with PIN attempt counter and tailgating block.
// Latency: 1 cycle from input at rising edge to registered outputs.
// Ports: Clk, Reset (async active-low), bus (slave modport). No backpressure.
module control_compuerta
  import compuerta_pkg::*;
#(
  parameter logic [7:0] PIN_CORRECTO = PIN_DEFECTO,
  parameter int         MAX_INTENTOS = MAX_INTENTOS_DEF   // legal 1..3
) (
  input  logic                Clk,
  input  logic                Reset,
  control_compuerta_if.slave  bus
);

  localparam logic [2:0] MAX_W   = 3'(MAX_INTENTOS);
  localparam logic [1:0] MAX_SAT = MAX_W[1:0];

  estado_t    estado, estado_sig;
  logic [1:0] intentos, intentos_sig;
  logic [2:0] intentos_p1;
  salidas_t   salidas;
  logic       pin_ev, pin_ok, pin_bad;

  detector_flanco u_flanco (
    .Clk   (Clk),
    .Reset (Reset),
    .in    (bus.enterPin),
    .pulso (pin_ev)
  );

  assign pin_ok      = pin_ev & (bus.Pin == PIN_CORRECTO);
  assign pin_bad     = pin_ev & (bus.Pin != PIN_CORRECTO);
  // Widened so the compare against MAX_INTENTOS cannot wrap.
  assign intentos_p1 = {1'b0, intentos} + 3'd1;

  always_comb begin
    estado_sig   = estado;
    intentos_sig = intentos;
    unique case (estado)
      CERRADO: begin
        if (bus.Vehiculo) estado_sig = ESPERA_PIN;
      end
      ESPERA_PIN: begin
        if (pin_ok) begin
          estado_sig = ABIERTO;
        end else if (pin_bad && (intentos_p1 == MAX_W)) begin
          estado_sig   = ALARMA_PIN;
          intentos_sig = MAX_SAT;
        end else if (pin_bad) begin
          intentos_sig = intentos_p1[1:0];
        end else if (!bus.Vehiculo) begin
          estado_sig = CERRADO;
        end
      end
      ALARMA_PIN: begin
        // Further wrong PINs keep the alarm; the counter stays saturated.
        if (pin_ok) estado_sig = ABIERTO;
      end
      ABIERTO: begin
        // A second vehicle still present when the first finishes is tailgating.
        if (bus.Termino && bus.Vehiculo) estado_sig = BLOQUEO;
        else if (bus.Termino)            estado_sig = CERRADO;
      end
      BLOQUEO: begin
        if (pin_ok) estado_sig = CERRADO;
      end
      default: estado_sig = CERRADO;
    endcase
    // Every entry to CERRADO or ABIERTO starts a fresh attempt window.
    if (estado_sig == CERRADO || estado_sig == ABIERTO) intentos_sig = 2'd0;
  end

  // Outputs are registered from the next state so they line up with the
  // state register and reset asynchronously with it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      estado   <= CERRADO;
      intentos <= 2'd0;
      salidas  <= decodificar(CERRADO);
    end else begin
      estado   <= estado_sig;
      intentos <= intentos_sig;
      salidas  <= decodificar(estado_sig);
    end
  end

  assign bus.Cerrado = salidas.cerrado;
  assign bus.Abierto = salidas.abierto;
  assign bus.Alarma  = salidas.alarma;
  assign bus.Bloqueo = salidas.bloqueo;

endmodule

// File: tb/tb_control_compuerta.sv
// Purpose: self-checking bench for control_compuerta: directed scenarios plus
//          randomized traffic against a flag-based behavioural model.
// Outputs are compared as {Cerrado, Abierto, Alarma, Bloqueo}.
module tb_control_compuerta;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: the gate described as a set of flags and a wrong-PIN tally.
  bit m_waiting, m_open, m_alarm, m_blocked, m_prev_en;
  int m_wrong;

  control_compuerta_if bus();

  control_compuerta dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] outs();
    return {bus.Cerrado, bus.Abierto, bus.Alarma, bus.Bloqueo};
  endfunction

  function automatic logic [3:0] expected();
    return {!m_open, m_open, m_alarm | m_blocked, m_blocked};
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got CAAB=%b expected CAAB=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_waiting = 0; m_open = 0; m_alarm = 0; m_blocked = 0; m_prev_en = 0; m_wrong = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit ev, ok, bad;
    ev = bus.enterPin && !m_prev_en;
    m_prev_en = bus.enterPin;
    ok  = ev && (bus.Pin == 8'h10);
    bad = ev && (bus.Pin != 8'h10);
    if (m_blocked) begin
      if (ok) m_blocked = 0;
    end else if (m_open) begin
      if (bus.Termino) begin
        m_open = 0;
        m_blocked = bus.Vehiculo;
      end
    end else if (m_alarm) begin
      if (ok) begin m_alarm = 0; m_open = 1; m_wrong = 0; end
    end else if (m_waiting) begin
      if (ok) begin
        m_waiting = 0; m_open = 1; m_wrong = 0;
      end else if (bad) begin
        m_wrong++;
        if (m_wrong >= 3) begin m_waiting = 0; m_alarm = 1; end
      end else if (!bus.Vehiculo) begin
        m_waiting = 0; m_wrong = 0;
      end
    end else if (bus.Vehiculo) begin
      m_waiting = 1; m_wrong = 0;
    end
  endtask

  task automatic step(input logic v, input logic t, input logic e, input logic [7:0] p,
                      input string tag);
    @(negedge clk);
    bus.Vehiculo = v; bus.Termino = t; bus.enterPin = e; bus.Pin = p;
    @(posedge clk);
    if (rst_n) model_step();
    #1 chk(tag, outs(), expected());
  endtask

  // One enterPin pulse: high for a cycle, then low for a cycle.
  task automatic pulse(input logic v, input logic [7:0] p, input string tag);
    step(v, 1'b0, 1'b1, p, tag);
    step(v, 1'b0, 1'b0, p, tag);
  endtask

  // Reset asserted between clock edges must clear outputs without a clock.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk(tag, outs(), 4'b1000);
    model_reset();
    bus.Vehiculo = 0; bus.Termino = 0; bus.enterPin = 0; bus.Pin = 8'h00;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic v, t, e;
    logic [7:0] p;
    bus.Vehiculo = 0; bus.Termino = 0; bus.enterPin = 0; bus.Pin = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk("reset_state", outs(), 4'b1000);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic admit and close.
    step(1, 0, 0, 8'h00, "veh_arrive");
    chk("veh_wait_closed", outs(), 4'b1000);
    step(1, 0, 1, 8'h10, "pin_ok");
    chk("pin_ok_open", outs(), 4'b0100);
    step(0, 1, 0, 8'h10, "termino");
    chk("termino_closed", outs(), 4'b1000);

    // Three wrong PINs raise the alarm, a fourth keeps it, correct PIN opens.
    step(1, 0, 0, 8'hFF, "veh2");
    for (int i = 0; i < 3; i++) begin
      pulse(1, 8'hFF, "wrong_pin");
      chk("wrong_pin_alarm", outs(), (i < 2) ? 4'b1000 : 4'b1010);
    end
    pulse(1, 8'hFF, "wrong_pin4");
    chk("wrong4_alarm_kept", outs(), 4'b1010);
    pulse(1, 8'h10, "alarm_pin_ok");
    chk("alarm_cleared_open", outs(), 4'b0100);
    step(0, 1, 0, 8'h00, "close2");

    // Pin changes without an edge do nothing; a held strobe counts once.
    step(1, 0, 0, 8'hFF, "veh3");
    step(1, 0, 0, 8'h10, "pin_no_edge");
    chk("pin_no_edge_stay", outs(), 4'b1000);
    step(1, 0, 0, 8'h33, "pin_no_edge2");
    for (int i = 0; i < 3; i++) step(1, 0, 1, 8'hFF, "held_strobe");
    step(1, 0, 0, 8'hFF, "held_release");
    pulse(1, 8'hFF, "after_hold1");
    chk("held_counts_once", outs(), 4'b1000);
    pulse(1, 8'hFF, "after_hold2");
    chk("held_then_alarm", outs(), 4'b1010);
    pulse(1, 8'h10, "open3");

    // Tailgating block: wrong PIN ignored, correct PIN closes.
    step(1, 1, 0, 8'h00, "tailgate");
    chk("tailgate_block", outs(), 4'b1011);
    pulse(1, 8'hFF, "block_wrong");
    chk("block_wrong_ignored", outs(), 4'b1011);
    pulse(0, 8'h10, "block_ok");
    chk("block_ok_closed", outs(), 4'b1000);

    // Counter clears when the vehicle leaves.
    step(1, 0, 0, 8'h00, "veh4");
    pulse(1, 8'hFF, "one_wrong");
    step(0, 0, 0, 8'h00, "veh_leave");
    step(1, 0, 0, 8'h00, "veh5");
    for (int i = 0; i < 3; i++) begin
      pulse(1, 8'hFF, "fresh_wrong");
      chk("counter_cleared", outs(), (i < 2) ? 4'b1000 : 4'b1010);
    end

    // Asynchronous reset from ALARMA_PIN and from BLOQUEO.
    async_reset("async_rst_alarm");
    step(1, 0, 0, 8'h00, "veh6");
    pulse(1, 8'h10, "open6");
    step(1, 1, 0, 8'h00, "tailgate6");
    chk("tailgate6_block", outs(), 4'b1011);
    async_reset("async_rst_block");

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      v = ($urandom_range(0, 99) < 70);
      t = ($urandom_range(0, 3) == 0);
      e = 1'($urandom_range(0, 1));
      p = ($urandom_range(0, 2) == 0) ? 8'h10 : 8'($urandom);
      if ($urandom_range(0, 299) == 0) async_reset("rand_async_rst");
      else step(v, t, e, p, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
